logic_pod_compression: RTL and testbench
========================================

Name: logic_pod_compression

Overview:
- Run-length compressor for one logic-pod sample lane in the SATA sniffer capture path.
- Each clock delivers 16 consecutive 1-bit samples; din[0] is the earliest sample.
- All-0 or all-1 words (idle/static line) are merged into run records.
- Any other word passes through as a literal record, ahead of the capture memory writer.

Parameters:
- MAX_RUN, 32767, maximum word count held in one run record; legal range 1..32767.

Ports:
- clk  input  1  capture clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  16  16 samples for this cycle
- din_valid  input  1  din is consumed only when 1
- flush  input  1  force emission of the open run, if any
- run_valid  output  1  run_data holds a completed run record
- run_data  output  16  [15]=level, [14:0]=count of constant words
- lit_valid  output  1  lit_data holds a literal record
- lit_data  output  16  raw din word

Behaviour:
- Reset (asynchronous, rst_n low): run_valid=0, lit_valid=0, run_data=0, lit_data=0, no open run, count=0.
- Reset is asynchronous on assertion; a run open when reset asserts is discarded with no record emitted.
- Internal state: run_open flag, run_level (1 bit), run_count (15 bits).
- Outputs are registered: a record caused by the input sampled at edge N is valid during the cycle after edge N.
- Valid outputs are single-cycle pulses.
- No backpressure; downstream must accept every record.
- Constant word means din==16'h0000 (level 0) or din==16'hFFFF (level 1).
- Constant word, run open, same level, run_count<MAX_RUN: run_count+=1. No output.
- Constant word, run open, same level, run_count==MAX_RUN: emit run record {level, MAX_RUN}; start a new run with count 1.
- Constant word, run open, different level: emit the old run record; start a new run at the new level with count 1.
- Constant word, no run open: start a run with count 1. No output.
- Non-constant word, run open: emit the run record on the run lane and din on the literal lane in the same cycle; close the run.
- Non-constant word, no run open: emit a literal only.
- Ordering when run_valid and lit_valid are both high: the run record precedes the literal in the stream.
- din_valid=0: state is unchanged and no literal is produced.
- flush=1 with run open: emit the run record and close the run.
  - If a word is consumed in the same cycle, the word is processed first.
  - If the word is constant and extends the run, the extended run is emitted.
  - If the word is constant and starts a new run, the new run is also closed; the old run is emitted first. At most one run record per cycle, so the old run is emitted this cycle and the new run next cycle.
- flush with no run open: no output.
- Run records always carry count >= 1.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with din toggling -> run_valid=lit_valid=0; release rst_n and drive 0x0000 -> no output (run opens, count 1).
- Run merging, din_valid=1 each cycle, sequence 0000,0000,FFFF,0000 -> run records 0x0002 then 0x8001, each one cycle after the causing word.
- Dual emission, continuing the previous sequence with 00FF,F0F0,00FF -> first cycle run_data=0x0001 and lit_data=0x00FF together; then literals 0xF0F0 and 0x00FF alone.
- Mixed sequence FFFF,FFFF,FF00,0055,0000 -> run 0x8002 plus literal 0xFF00 in the same cycle, then literal 0x0055; run for 0x0000 stays open with no output until flush=1, then run_data=0x0001.
- Saturation with MAX_RUN=4: seven consecutive 0xFFFF words, then flush -> run records 0x8004, then 0x8003.
- din_valid gaps: 0000, idle 5 cycles with din_valid=0, 0000, then 1234 -> run 0x0002 plus literal 0x1234; no output during the idle cycles.

Source files
------------

// File: rtl/logic_pod_compression_if.sv
// Bus bundle for the logic-pod run-length compressor.
//
// Signals:
//   din[15:0]       16 samples per clock, din[0] is the earliest sample
//   din_valid       din is consumed only when 1
//   flush           force emission of the open run, if any
//   run_valid       run_data holds a completed run record (single-cycle pulse)
//   run_data[15:0]  [15]=level, [14:0]=count of constant words
//   lit_valid       lit_data holds a literal record (single-cycle pulse)
//   lit_data[15:0]  raw din word
//
// Modports:
//   master - the producer of samples and consumer of records
//   slave  - the compressor
interface logic_pod_compression_if;
    logic [15:0] din;
    logic        din_valid;
    logic        flush;
    logic        run_valid;
    logic [15:0] run_data;
    logic        lit_valid;
    logic [15:0] lit_data;

    modport master (
        output din, din_valid, flush,
        input  run_valid, run_data, lit_valid, lit_data
    );

    modport slave (
        input  din, din_valid, flush,
        output run_valid, run_data, lit_valid, lit_data
    );
endinterface

// File: rtl/logic_pod_compression.sv
// Run-length compressor for one logic-pod sample lane.
//
// All-0 / all-1 words are merged into run records; any other word is passed
// through as a literal record.
//
// Ports:
//   clk    capture clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    logic_pod_compression_if.slave (din/din_valid/flush in,
//          run_valid/run_data/lit_valid/lit_data out)
//
// Handshake: din is taken on every rising edge where din_valid=1; there is no
// backpressure. run_valid and lit_valid are single-cycle pulses valid in the
// cycle after the causing edge, and the downstream must accept every pulse.
// When both pulse together, the run record precedes the literal in the stream.
module logic_pod_compression #(
    parameter int MAX_RUN = 32767
) (
    input  logic                          clk,
    input  logic                          rst_n,
    logic_pod_compression_if.slave        bus
);

    localparam logic [14:0] MAX_C = 15'(MAX_RUN);

    logic        run_valid_q, run_valid_d;
    logic [15:0] run_data_q,  run_data_d;
    logic        lit_valid_q, lit_valid_d;
    logic [15:0] lit_data_q,  lit_data_d;
    logic        run_open_q,  run_open_d;
    logic        run_level_q, run_level_d;
    logic [14:0] run_count_q, run_count_d;
    // A flushed single-word run that could not be emitted in its own cycle
    // because the run lane was already busy; it always has count 1.
    logic        pend_q,       pend_d;
    logic        pend_level_q, pend_level_d;

    logic        is_const;
    logic        word_level;
    logic        run_emit;

    always_comb begin
        run_valid_d  = 1'b0;
        run_data_d   = run_data_q;
        lit_valid_d  = 1'b0;
        lit_data_d   = lit_data_q;
        run_open_d   = run_open_q;
        run_level_d  = run_level_q;
        run_count_d  = run_count_q;
        pend_d       = 1'b0;
        pend_level_d = pend_level_q;
        run_emit     = 1'b0;
        is_const     = (bus.din == 16'h0000) || (bus.din == 16'hFFFF);
        word_level   = bus.din[0];

        // A pending record implies no run was open, so no word below can
        // also want the run lane from an old run in this cycle.
        if (pend_q) begin
            run_valid_d = 1'b1;
            run_data_d  = {pend_level_q, 15'd1};
            run_emit    = 1'b1;
        end

        if (bus.din_valid) begin
            if (is_const) begin
                if (run_open_q && (run_level_q == word_level) && (run_count_q < MAX_C)) begin
                    run_count_d = run_count_q + 15'd1;
                end else begin
                    // Level change or saturated count closes the old run.
                    if (run_open_q) begin
                        run_valid_d = 1'b1;
                        run_data_d  = {run_level_q, run_count_q};
                        run_emit    = 1'b1;
                    end
                    run_open_d  = 1'b1;
                    run_level_d = word_level;
                    run_count_d = 15'd1;
                end
            end else begin
                lit_valid_d = 1'b1;
                lit_data_d  = bus.din;
                if (run_open_q) begin
                    run_valid_d = 1'b1;
                    run_data_d  = {run_level_q, run_count_q};
                    run_open_d  = 1'b0;
                    run_count_d = 15'd0;
                end
            end
        end

        // Flush acts on the run as left by this cycle's word. If the run lane
        // is already taken, the (fresh, count 1) run goes out next cycle.
        if (bus.flush && run_open_d) begin
            if (run_emit) begin
                pend_d       = 1'b1;
                pend_level_d = run_level_d;
            end else begin
                run_valid_d = 1'b1;
                run_data_d  = {run_level_d, run_count_d};
            end
            run_open_d  = 1'b0;
            run_count_d = 15'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_valid_q  <= 1'b0;
            run_data_q   <= 16'h0000;
            lit_valid_q  <= 1'b0;
            lit_data_q   <= 16'h0000;
            run_open_q   <= 1'b0;
            run_level_q  <= 1'b0;
            run_count_q  <= 15'd0;
            pend_q       <= 1'b0;
            pend_level_q <= 1'b0;
        end else begin
            run_valid_q  <= run_valid_d;
            run_data_q   <= run_data_d;
            lit_valid_q  <= lit_valid_d;
            lit_data_q   <= lit_data_d;
            run_open_q   <= run_open_d;
            run_level_q  <= run_level_d;
            run_count_q  <= run_count_d;
            pend_q       <= pend_d;
            pend_level_q <= pend_level_d;
        end
    end

    assign bus.run_valid = run_valid_q;
    assign bus.run_data  = run_data_q;
    assign bus.lit_valid = lit_valid_q;
    assign bus.lit_data  = lit_data_q;

endmodule

// File: tb/tb_logic_pod_compression.sv
// Testbench for logic_pod_compression (built with MAX_RUN=4 so saturation is
// reachable). The reference model emits records into an ordered stream; run
// records go through a queue that the run lane drains one per cycle.
module tb_logic_pod_compression;

    localparam int TB_MAX = 4;

    logic clk;
    logic rst_n;

    logic_pod_compression_if bus_if ();

    logic_pod_compression #(.MAX_RUN(TB_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // reference model state
    logic [15:0] run_q[$];
    bit          m_open;
    bit          m_level;
    int          m_count;
    logic [33:0] exp_vec;

    task automatic model_reset();
        run_q.delete();
        m_open  = 0;
        m_level = 0;
        m_count = 0;
    endtask

    task automatic model_close();
        logic [31:0] c;
        c = m_count;
        run_q.push_back({m_level, c[14:0]});
        m_open  = 0;
        m_count = 0;
    endtask

    // Expected {run_valid, run_data, lit_valid, lit_data} for one edge, data
    // zeroed when its valid is low.
    task automatic model_cycle(input logic [15:0] d, input bit v, input bit f,
                               output logic [33:0] e);
        logic [15:0] lit;
        logic [15:0] rr;
        bit          lv;
        bit          rv;
        lit = 16'h0;
        lv  = 0;
        if (v) begin
            if (d == 16'h0000 || d == 16'hFFFF) begin
                if (m_open && m_level == d[0] && m_count < TB_MAX) begin
                    m_count++;
                end else begin
                    if (m_open) model_close();
                    m_open  = 1;
                    m_level = d[0];
                    m_count = 1;
                end
            end else begin
                if (m_open) model_close();
                lv  = 1;
                lit = d;
            end
        end
        if (f && m_open) model_close();
        rv = 0;
        rr = 16'h0;
        if (run_q.size() > 0) begin
            rv = 1;
            rr = run_q.pop_front();
        end
        e = {rv, rr, lv, lit};
    endtask

    function automatic logic [33:0] obs();
        return {bus_if.run_valid, bus_if.run_valid ? bus_if.run_data : 16'h0,
                bus_if.lit_valid, bus_if.lit_valid ? bus_if.lit_data : 16'h0};
    endfunction

    // driver: present inputs at the falling edge, sample 1 ns after rising edge
    task automatic drive(input logic [15:0] d, input bit v, input bit f);
        @(negedge clk);
        bus_if.din       = d;
        bus_if.din_valid = v;
        bus_if.flush     = f;
        model_cycle(d, v, f, exp_vec);
        @(posedge clk);
        #1;
        bus_if.din_valid = 1'b0;
        bus_if.flush     = 1'b0;
    endtask

    task automatic run_seq(input string name, input logic [15:0] d[], input bit v[], input bit f[]);
        logic [33:0] o;
        for (int i = 0; i < d.size(); i++) begin
            drive(d[i], v[i], f[i]);
            o = obs();
            n_vec++;
            if (o !== exp_vec) begin
                n_err++;
                $display("FAIL %s step %0d: got rv=%0b rd=%h lv=%0b ld=%h, want rv=%0b rd=%h lv=%0b ld=%h",
                         name, i, o[33], o[32:17], o[16], o[15:0],
                         exp_vec[33], exp_vec[32:17], exp_vec[16], exp_vec[15:0]);
            end
        end
    endtask

    task automatic test_reset();
        logic [49:0] o;
        rst_n = 1'b0;
        bus_if.din = 16'h0; bus_if.din_valid = 1'b0; bus_if.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.din       = 16'($urandom);
            bus_if.din_valid = 1'b1;
            @(posedge clk);
            #1;
            o = {16'h0, bus_if.run_valid, bus_if.run_data, bus_if.lit_valid, bus_if.lit_data};
            n_vec++;
            if (o[33:0] !== 34'h0) begin
                n_err++;
                $display("FAIL reset cycle %0d: got outputs %h, want 0", i, o[33:0]);
            end
        end
        @(negedge clk);
        bus_if.din_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        run_seq("reset_first_word", '{16'h0000}, '{1}, '{0});
    endtask

    task automatic test_run_merge();
        run_seq("run_merge", '{16'h0000, 16'hFFFF, 16'h0000}, '{1, 1, 1}, '{0, 0, 0});
    endtask

    task automatic test_dual();
        run_seq("dual", '{16'h00FF, 16'hF0F0, 16'h00FF}, '{1, 1, 1}, '{0, 0, 0});
    endtask

    task automatic test_mixed();
        run_seq("mixed", '{16'hFFFF, 16'hFFFF, 16'hFF00, 16'h0055, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                '{1, 1, 1, 1, 1, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 1, 0});
    endtask

    task automatic test_saturation();
        run_seq("saturation",
                '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0},
                '{1, 1, 1, 1, 1, 1, 1, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 1, 0});
    endtask

    task automatic test_gaps();
        run_seq("gaps",
                '{16'h0000, 16'hFFFF, 16'h1234, 16'h0000, 16'hABCD, 16'h5555, 16'h0000, 16'h1234, 16'h0},
                '{1, 0, 0, 0, 0, 0, 1, 1, 0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    endtask

    // flush landing on a word that opens a new run while the old one is emitted
    task automatic test_flush_new_run();
        run_seq("flush_new_run",
                '{16'h0000, 16'hFFFF, 16'h0000, 16'h0, 16'hFFFF, 16'h0,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0, 16'h0},
                '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0},
                '{0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1});
    endtask

    task automatic test_async_reset();
        logic [33:0] o;
        run_seq("pre_async", '{16'h0000, 16'h0000, 16'hFFFF}, '{1, 1, 1}, '{0, 0, 0});
        #2;
        rst_n = 1'b0;
        #1;
        o = {bus_if.run_valid, bus_if.run_data, bus_if.lit_valid, bus_if.lit_data};
        n_vec++;
        if (o !== 34'h0) begin
            n_err++;
            $display("FAIL async_reset: got outputs %h, want 0", o);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_seq("post_async", '{16'h0000, 16'h0}, '{1, 0}, '{1, 0});
    endtask

    task automatic test_random();
        logic [15:0] d[];
        bit          v[];
        bit          f[];
        int          r;
        d = new[400];
        v = new[400];
        f = new[400];
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      d[i] = 16'h0000;
            else if (r < 7) d[i] = 16'hFFFF;
            else            d[i] = 16'($urandom);
            v[i] = ($urandom_range(0, 9) < 8);
            f[i] = ($urandom_range(0, 9) == 0);
        end
        run_seq("random", d, v, f);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_run_merge();
        test_dual();
        test_mixed();
        test_saturation();
        test_gaps();
        test_flush_new_run();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
